hsid_min_dist_sel: RTL
======================

// Module: hsid_min_dist_sel
// PURPOSE
//   Downstream consumer of the squared-difference accumulator. Watches the accumulator
//   output stream, treats each acc_last beat as the final distance of one library
//   reference, and tracks the minimum and maximum distance with their acc_ref over one
//   search of library_size references.
//   Reports the best match (min) to the classifier with a one-cycle done pulse.
// PARAMETERS
//   DATA_WIDTH_ACC     HSID_DATA_WIDTH_ACC      width of distance values (acc_value)
//   HSP_LIBRARY_WIDTH  HSID_HSP_LIBRARY_WIDTH   width of library reference index (acc_ref)
// PORTS
//   clk           in   1                    clock, rising edge
//   rst_n         in   1                    async reset, active low
//   start         in   1                    begin new search (one-cycle pulse)
//   library_size  in   HSP_LIBRARY_WIDTH+1  references expected this search, sampled on start
//   acc_valid     in   1                    accumulator beat valid
//   acc_value     in   DATA_WIDTH_ACC       accumulated distance
//   acc_last      in   1                    beat is final distance of one reference
//   acc_ref       in   HSP_LIBRARY_WIDTH    reference index of that beat
//   busy          out  1                    search in progress (RUN state)
//   done          out  1                    one-cycle pulse, results valid
//   min_ref       out  HSP_LIBRARY_WIDTH    index of smallest distance
//   min_value     out  DATA_WIDTH_ACC       smallest distance
//   max_ref       out  HSP_LIBRARY_WIDTH    index of largest distance
//   max_value     out  DATA_WIDTH_ACC       largest distance
//   result_count  out  HSP_LIBRARY_WIDTH+1  candidates accepted in current/last search
// BEHAVIOUR
//   - Reset: state IDLE; busy=0, done=0, min/max ref/value=0, result_count=0, size reg=0.
//   - FSM IDLE -> RUN on start with library_size!=0; start with library_size==0 ignored.
//     Entering RUN: latch library_size, result_count=0, min_value=all-ones, max_value=0.
//   - RUN: candidate = acc_valid && acc_last. Non-last valid beats (partial sums) ignored.
//     First candidate loads min and max unconditionally. Later: min updated only if
//     acc_value < min_value, max only if acc_value > max_value (strict: ties keep earliest).
//     Compare unsigned, full DATA_WIDTH_ACC, no truncation. result_count += 1 per candidate.
//   - RUN -> DONE on the candidate that makes result_count == latched size, in same cycle.
//     DONE lasts exactly one cycle: done=1, busy=0, outputs already final -> IDLE.
//     Latency: done high one cycle after the final candidate is sampled.
//   - Outputs registered; held stable after done until the next accepted start.
//   - Candidates while IDLE/DONE ignored (no output or count change).
//   - start while RUN: abort, re-enter RUN with new library_size, counters/min/max re-init;
//     a candidate in that same cycle is discarded. start during DONE: done still pulses,
//     next state RUN (re-init).
//   - busy=1 exactly in RUN.
//   - Reset mid-search: all state cleared immediately; no done pulse.
//   - acc_ref not checked for order or duplicates; reported verbatim.
// TESTING
//   1. Reset: rst_n=0 mid-RUN -> all outputs 0 asynchronously, busy=0, no done.
//   2. start size=4; candidates (ref,val)=(0,50),(1,20),(2,90),(3,35) with gaps and
//      non-last beats interleaved -> done 1 cycle after ref 3; min=(1,20), max=(2,90),
//      result_count=4.
//   3. Ties: size=3, values 7,7,7 refs 0..2 -> min_ref=0, max_ref=0, values 7.
//   4. Extremes: size=2, values 0 and 2^DATA_WIDTH_ACC-1 -> min_value=0,
//      max_value=all-ones; size=1 single candidate -> min=max=that beat.
//   5. Abort: start size=5, 2 candidates, start size=2, 2 candidates (10,3) -> done after
//      second, min=(ref,3), result_count=2; library_size=0 start -> stays IDLE, no done.
//   6. Stray input: candidates before start and after done -> outputs unchanged; random
//      gaps in acc_valid, 16 searches vs. software argmin/argmax model.

Source files
------------

// File: rtl/hsid_min_dist_sel.sv
// hsid_min_dist_sel
// Watches the accumulator output stream and keeps the smallest and largest final
// distance (with its reference index) over one search of library_size references.
// A one-cycle done pulse marks the point where the results are final.
module hsid_min_dist_sel #(
  parameter int DATA_WIDTH_ACC    = 24,
  parameter int HSP_LIBRARY_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [HSP_LIBRARY_WIDTH:0]   library_size,
  input  logic                         acc_valid,
  input  logic [DATA_WIDTH_ACC-1:0]    acc_value,
  input  logic                         acc_last,
  input  logic [HSP_LIBRARY_WIDTH-1:0] acc_ref,
  output logic                         busy,
  output logic                         done,
  output logic [HSP_LIBRARY_WIDTH-1:0] min_ref,
  output logic [DATA_WIDTH_ACC-1:0]    min_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] max_ref,
  output logic [DATA_WIDTH_ACC-1:0]    max_value,
  output logic [HSP_LIBRARY_WIDTH:0]   result_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                       state_reg;
  logic [HSP_LIBRARY_WIDTH:0]   size_reg;

  logic                         candidate;
  logic                         start_ok;
  logic                         first_cand;
  logic [HSP_LIBRARY_WIDTH:0]   count_inc;

  // Only the final beat of a reference is a distance; partial sums never qualify.
  assign candidate  = acc_valid && acc_last;
  // A zero-length search would never finish, so such a start is ignored.
  assign start_ok   = start && (library_size != '0);
  assign first_cand = (result_count == '0);
  assign count_inc  = result_count + 1'b1;

  // Search FSM with all outputs registered; start always wins over a same-cycle candidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      size_reg     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      min_ref      <= '0;
      min_value    <= '0;
      max_ref      <= '0;
      max_value    <= '0;
      result_count <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done <= 1'b0;
          if (start_ok) begin
            state_reg    <= ST_RUN;
            busy         <= 1'b1;
            size_reg     <= library_size;
            result_count <= '0;
            min_value    <= '1;
            max_value    <= '0;
          end
        end

        ST_RUN: begin
          if (start_ok) begin
            // Abort and restart with the new size; any candidate this cycle is dropped.
            size_reg     <= library_size;
            result_count <= '0;
            min_value    <= '1;
            max_value    <= '0;
          end else if (candidate) begin
            result_count <= count_inc;
            // Strict compares keep the earliest reference on ties.
            if (first_cand || (acc_value < min_value)) begin
              min_value <= acc_value;
              min_ref   <= acc_ref;
            end
            if (first_cand || (acc_value > max_value)) begin
              max_value <= acc_value;
              max_ref   <= acc_ref;
            end
            if (count_inc == size_reg) begin
              state_reg <= ST_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          done <= 1'b0;
          if (start_ok) begin
            state_reg    <= ST_RUN;
            busy         <= 1'b1;
            size_reg     <= library_size;
            result_count <= '0;
            min_value    <= '1;
            max_value    <= '0;
          end else begin
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
